traffic_src: RTL and testbench

Stimulus source that drives the read-request stream consumed by the traffic generator accelerator kernel. Emits `n_total_reqs` data words over a valid/ready stream in bursts of `t_ck_reqs` accepted beats, separated by `t_ck_idle` idle cycles, under the same `ap_start`/`ap_done` control handshake. Sits upstream of the kernel's `r_reqs` input in standalone and streamer-bypass test setups.

---
 rtl/traffic_src.sv | 120 ++++++++++++
 tb/tb_traffic_src.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_src.sv
// traffic_src: bursty valid/ready request-stream source with ap_start/ap_done control.
// Optional TRAFFIC_SRC_LFSR_EN selects a 32-bit Galois LFSR data generator
// (x^32+x^22+x^2+x+1, seed 32'hACE1_2468) instead of the default incrementing counter.
module traffic_src #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    output logic                  r_reqs_TVALID,
    input  logic                  r_reqs_TREADY,
    output logic [WORD_WIDTH-1:0] r_reqs_TDATA,
    input  logic [WORD_WIDTH-1:0] n_total_reqs,
    input  logic [WORD_WIDTH-1:0] t_ck_reqs,
    input  logic [WORD_WIDTH-1:0] t_ck_idle,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_idle,
    output logic                  ap_ready,
    output logic [WORD_WIDTH-1:0] sent_cnt
);
    typedef enum logic [1:0] {IDLE, BURST, GAP, DONE} state_t;

    localparam logic [WORD_WIDTH-1:0] ONE = 1;

    state_t state, state_d;
    logic [WORD_WIDTH-1:0] n_q, n_d, reqs_q, reqs_d, idle_q, idle_d;
    logic [WORD_WIDTH-1:0] sent_q, sent_d, burst_q, burst_d, gap_q, gap_d;
    logic [WORD_WIDTH-1:0] sent_inc, burst_inc, gap_inc;

`ifdef TRAFFIC_SRC_LFSR_EN
    localparam logic [31:0] GEN_INIT = 32'hACE1_2468;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    logic [31:0] gen_q, gen_d, gen_step;
    assign gen_step = {1'b0, gen_q[31:1]} ^ (gen_q[0] ? LFSR_TAPS : 32'h0);
    assign r_reqs_TDATA = WORD_WIDTH'(gen_q);
`else
    localparam logic [WORD_WIDTH-1:0] GEN_INIT = '0;
    logic [WORD_WIDTH-1:0] gen_q, gen_d, gen_step;
    assign gen_step = gen_q + ONE;
    assign r_reqs_TDATA = gen_q;
`endif

    assign sent_inc = sent_q + ONE;
    assign burst_inc = burst_q + ONE;
    assign gap_inc = gap_q + ONE;

    // Outputs decode straight from the state register, so TVALID never sees TREADY.
    assign r_reqs_TVALID = state == BURST;
    assign ap_idle = state == IDLE;
    assign ap_done = state == DONE;
    assign ap_ready = state == DONE;
    assign sent_cnt = sent_q;

    // Next-state and datapath updates; leaving BURST happens only on a beat.
    always_comb begin
        state_d = state;
        n_d = n_q;
        reqs_d = reqs_q;
        idle_d = idle_q;
        sent_d = sent_q;
        burst_d = burst_q;
        gap_d = gap_q;
        gen_d = gen_q;
        case (state)
            IDLE: begin
                if (ap_start) begin
                    n_d = n_total_reqs;
                    reqs_d = t_ck_reqs;
                    idle_d = t_ck_idle;
                    sent_d = '0;
                    burst_d = '0;
                    gap_d = '0;
                    gen_d = GEN_INIT;
                    state_d = (n_total_reqs == '0) ? DONE : BURST;
                end
            end
            BURST: begin
                if (r_reqs_TREADY) begin
                    sent_d = sent_inc;
                    burst_d = burst_inc;
                    gen_d = gen_step;
                    if (sent_inc == n_q) begin
                        state_d = DONE;
                    end else if (reqs_q != '0 && burst_inc == reqs_q) begin
                        burst_d = '0;
                        state_d = (idle_q != '0) ? GAP : BURST;
                    end
                end
            end
            GAP: begin
                gap_d = (gap_inc == idle_q) ? '0 : gap_inc;
                state_d = (gap_inc == idle_q) ? BURST : GAP;
            end
            DONE: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= IDLE;
            n_q <= '0;
            reqs_q <= '0;
            idle_q <= '0;
            sent_q <= '0;
            burst_q <= '0;
            gap_q <= '0;
            gen_q <= '0;
        end else begin
            state <= state_d;
            n_q <= n_d;
            reqs_q <= reqs_d;
            idle_q <= idle_d;
            sent_q <= sent_d;
            burst_q <= burst_d;
            gap_q <= gap_d;
            gen_q <= gen_d;
        end
    end
endmodule

// File: tb/tb_traffic_src.sv
// tb_traffic_src: table-driven and hand-sequenced checks of traffic_src with a data scoreboard.
module tb_traffic_src;
    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        r_reqs_TVALID;
    logic        r_reqs_TREADY = 1'b1;
    logic [31:0] r_reqs_TDATA;
    logic [31:0] n_total_reqs = '0;
    logic [31:0] t_ck_reqs = '0;
    logic [31:0] t_ck_idle = '0;
    logic        ap_start = 1'b0;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [31:0] sent_cnt;

    int checks = 0;
    int failures = 0;
    logic [31:0] sb[$];

    typedef struct {
        int n;
        int reqs;
        int idle;
        int done;
        int lo;
        int hi;
        int poke;
        logic [31:0] vmask;
    } vec_t;

    vec_t vecs[10];

    traffic_src #(.WORD_WIDTH(32)) dut (
        .ap_clk(ap_clk),
        .ap_rst(ap_rst),
        .r_reqs_TVALID(r_reqs_TVALID),
        .r_reqs_TREADY(r_reqs_TREADY),
        .r_reqs_TDATA(r_reqs_TDATA),
        .n_total_reqs(n_total_reqs),
        .t_ck_reqs(t_ck_reqs),
        .t_ck_idle(t_ck_idle),
        .ap_start(ap_start),
        .ap_done(ap_done),
        .ap_idle(ap_idle),
        .ap_ready(ap_ready),
        .sent_cnt(sent_cnt)
    );

    always #5 ap_clk = ~ap_clk;

`ifdef TRAFFIC_SRC_LFSR_EN
    function automatic logic [31:0] first_word();
        return 32'hACE1_2468;
    endfunction
    function automatic logic [31:0] next_word(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
    endfunction
`else
    function automatic logic [31:0] first_word();
        return 32'h0;
    endfunction
    function automatic logic [31:0] next_word(input logic [31:0] v);
        return v + 32'd1;
    endfunction
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fill_sb(input int n);
        logic [31:0] w;
        sb.delete();
        w = first_word();
        for (int i = 0; i < n; i++) begin
            sb.push_back(w);
            w = next_word(w);
        end
    endtask

    task automatic sample_data();
        if (r_reqs_TVALID) begin
            if (sb.size() == 0) begin
                chk("extra_beat", 32'd1, 32'd0);
            end else begin
                chk("tdata", r_reqs_TDATA, sb[0]);
                if (r_reqs_TREADY) void'(sb.pop_front());
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        fill_sb(v.n);
        n_total_reqs = v.n;
        t_ck_reqs = v.reqs;
        t_ck_idle = v.idle;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        for (int c = 1; c <= v.done + 1; c++) begin
            r_reqs_TREADY = !(c >= v.lo && c <= v.hi);
            ap_start = (c == v.poke);
            @(negedge ap_clk);
            chk("tvalid", {31'd0, r_reqs_TVALID}, {31'd0, v.vmask[c]});
            sample_data();
            chk("ap_done", {31'd0, ap_done}, {31'd0, c == v.done});
            chk("ap_ready", {31'd0, ap_ready}, {31'd0, c == v.done});
            if (c == v.done + 1) chk("ap_idle_after_done", {31'd0, ap_idle}, 32'd1);
            @(posedge ap_clk);
            #1;
        end
        ap_start = 1'b0;
        r_reqs_TREADY = 1'b1;
        chk("sent_cnt", sent_cnt, v.n);
        chk("sb_left", sb.size(), 32'd0);
        @(negedge ap_clk);
        chk("stay_idle", {30'd0, ap_idle, r_reqs_TVALID}, 32'd2);
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{5, 2, 3, 12, 0, 0, 0, 32'h8C6};
        vecs[1] = '{0, 0, 0, 1, 0, 0, 0, 32'h0};
        vecs[2] = '{8, 4, 0, 9, 0, 0, 4, 32'h1FE};
        vecs[3] = '{3, 0, 0, 8, 2, 5, 0, 32'hFE};
        vecs[4] = '{4, 1, 1, 8, 0, 0, 0, 32'hAA};
        vecs[5] = '{6, 3, 2, 9, 0, 0, 0, 32'h1CE};
        vecs[6] = '{3, 3, 5, 4, 0, 0, 0, 32'hE};
        vecs[7] = '{7, 0, 4, 8, 0, 0, 0, 32'hFE};
        vecs[8] = '{2, 0, 0, 3, 0, 0, 0, 32'h6};
        vecs[9] = '{2, 0, 0, 3, 0, 0, 0, 32'h6};

        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("rst_tvalid", {31'd0, r_reqs_TVALID}, 32'd0);
        chk("rst_tdata", r_reqs_TDATA, 32'd0);
        chk("rst_idle", {31'd0, ap_idle}, 32'd1);
        chk("rst_done_ready", {30'd0, ap_done, ap_ready}, 32'd0);
        chk("rst_sent", sent_cnt, 32'd0);
        @(posedge ap_clk);
        #1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // back-to-back jobs: restart in the first IDLE cycle after DONE
        fill_sb(1);
        n_total_reqs = 1;
        t_ck_reqs = 0;
        t_ck_idle = 0;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        @(negedge ap_clk);
        chk("b2b_valid1", {31'd0, r_reqs_TVALID}, 32'd1);
        sample_data();
        @(posedge ap_clk);
        #1;
        @(negedge ap_clk);
        chk("b2b_done1", {31'd0, ap_done}, 32'd1);
        @(posedge ap_clk);
        #1;
        fill_sb(1);
        ap_start = 1'b1;
        @(negedge ap_clk);
        chk("b2b_first_idle", {31'd0, ap_idle}, 32'd1);
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        @(negedge ap_clk);
        chk("b2b_valid2", {31'd0, r_reqs_TVALID}, 32'd1);
        sample_data();
        @(posedge ap_clk);
        #1;
        @(negedge ap_clk);
        chk("b2b_done2", {31'd0, ap_done}, 32'd1);
        chk("b2b_sb", sb.size(), 32'd0);
        @(posedge ap_clk);
        #1;

        // reset during the second burst aborts the job silently
        fill_sb(10);
        n_total_reqs = 10;
        t_ck_reqs = 3;
        t_ck_idle = 2;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge ap_clk);
            sample_data();
            @(posedge ap_clk);
            #1;
        end
        ap_rst = 1'b1;
        @(negedge ap_clk);
        chk("mid_sent", sent_cnt, 32'd4);
        chk("mid_valid", {31'd0, r_reqs_TVALID}, 32'd1);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("abort_valid", {31'd0, r_reqs_TVALID}, 32'd0);
        chk("abort_idle", {31'd0, ap_idle}, 32'd1);
        chk("abort_sent", sent_cnt, 32'd0);
        chk("abort_tdata", r_reqs_TDATA, 32'd0);
        for (int c = 0; c < 6; c++) begin
            chk("abort_no_done", {31'd0, ap_done}, 32'd0);
            @(negedge ap_clk);
        end
        @(posedge ap_clk);
        #1;
        run_vec(vecs[8]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
